// File: rtl/ram_seq_reader_if.sv
// ram_seq_reader_if: command, RAM read port and result bundle
// for the sequential RAM read/check engine.
interface ram_seq_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   err_cnt;
    logic              pass;

    // system side: issues commands, owns the RAM
    modport master (
        output start, base_addr, length, q,
        input  rdaddress, dout, dout_valid, busy, done, err_cnt, pass
    );

    // reader engine side
    modport slave (
        input  start, base_addr, length, q,
        output rdaddress, dout, dout_valid, busy, done, err_cnt, pass
    );
endinterface

// File: rtl/ram_seq_reader.sv
// ram_seq_reader: reads a wrapping address window from a RAM,
// streams the words and checks them against the word==address pattern.
module ram_seq_reader #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 2,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_seq_reader_if.slave bus
);
    localparam int EW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [RD_LAT-1:0] tag_v;
    logic [DATA_W-1:0] tag_e [RD_LAT];
    logic [DATA_W-1:0] dout_q;
    logic              dv_q;
    logic [ADDR_W:0]   err_q;
    logic              pass_q;
    logic [EW-1:0]     addr_ext;
    logic [DATA_W-1:0] exp_word;
    logic              accept;
    logic              last_issue;
    logic              head_v;
    logic              mismatch;

    assign accept     = (state == IDLE) && bus.start;
    assign last_issue = (state == READ) && (cnt == len_q);
    assign head_v     = tag_v[RD_LAT-1];
    assign addr_ext   = EW'(rd_addr);
    assign exp_word   = addr_ext[DATA_W-1:0];
    assign mismatch   = CHECK_EN && head_v
                        && (bus.q != tag_e[RD_LAT-1]);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.start)
                       state_nxt = (bus.length == '0) ? DONE : READ;
            READ:  if (cnt == len_q) state_nxt = DRAIN;
            DRAIN: if (tag_v == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
        bus.pass = (state == DONE) ? (err_q == '0) : pass_q;
    end

    // address issue, latency tag pipeline, output and error datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            len_q   <= '0;
            cnt     <= '0;
            rd_addr <= '0;
            tag_v   <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_e[i] <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            if (accept) begin
                base_q  <= bus.base_addr;
                len_q   <= bus.length;
                cnt     <= {{ADDR_W{1'b0}}, 1'b1};
                rd_addr <= (bus.length == '0) ? '0 : bus.base_addr;
            end else if (state == READ && !last_issue) begin
                rd_addr <= base_q + cnt[ADDR_W-1:0];
                cnt     <= cnt + 1'b1;
            end else begin
                rd_addr <= '0;
            end

            tag_v[0] <= (state == READ);
            tag_e[0] <= exp_word;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_e[i] <= tag_e[i-1];
            end

            dv_q <= head_v;
            if (head_v) dout_q <= bus.q;

            if (accept)
                err_q <= '0;
            else if (mismatch && err_q != '1)
                err_q <= err_q + 1'b1;

            if (accept)
                pass_q <= 1'b0;
            else if (state == DONE)
                pass_q <= (err_q == '0);
        end
    end

    assign bus.rdaddress  = rd_addr;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.err_cnt    = err_q;
endmodule

// File: tb/tb_ram_seq_reader.sv
// tb_ram_seq_reader: randomized runs of the reader against a RAM
// model and a per-run expectation built from the memory contents.
module tb_ram_seq_reader;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int N   = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_seq_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_seq_reader #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .CHECK_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // RAM read port: registered address plus registered output
    logic [DW-1:0] mem [N];
    logic [AW-1:0] ram_a;
    always @(posedge clk) begin
        ram_a <= bus.rdaddress;
        bus.q <= mem[ram_a];
    end

    int tests = 0;
    int fails = 0;
    bit last_pass = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdaddr"}, bus.rdaddress, 0);
        chk({tag, "_dout"}, bus.dout, 0);
        chk({tag, "_dv"}, bus.dout_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err_cnt, 0);
        chk({tag, "_pass"}, bus.pass, 0);
    endtask

    // one run: start in cycle 0, k counts the cycles after it
    task automatic run(input int base, input int len, input int ign1,
                       input int ign2, input int rst_at);
        int exp_q[$];
        int err_exp = 0;
        int k = 0;
        int nv = 0;
        int done_k;
        int a;
        bit fin = 1'b0;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % N;
            exp_q.push_back(int'(mem[a]));
            if (int'(mem[a]) != a) err_exp++;
        end
        done_k = (len == 0) ? 1 : len + LAT + 2;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("pass_hold", bus.pass, last_pass);
        bus.start = 1'b1;
        bus.base_addr = AW'(base);
        bus.length = (AW + 1)'(len);
        while (!fin) begin
            @(negedge clk);
            k++;
            bus.start = (k == ign1) || (k == ign2);
            bus.base_addr = AW'($urandom);
            bus.length = (AW + 1)'($urandom_range(1, N));
            if (k == rst_at) begin
                bus.start = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_zero("midrst");
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_dv", bus.dout_valid, 0);
                    chk("rst_done", bus.done, 0);
                end
                rst_n = 1'b1;
                last_pass = 1'b0;
                fin = 1'b1;
            end else begin
                chk("rdaddress", bus.rdaddress,
                    (k <= len) ? (base + k - 1) % N : 0);
                chk("busy", bus.busy, 1);
                if (k == 1 && len > 0) chk("pass_clr", bus.pass, 0);
                if (bus.dout_valid) begin
                    chk("dv_win", (k >= LAT + 2 && k <= len + LAT + 1), 1);
                    chk("dout", bus.dout,
                        (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead);
                    nv++;
                end
                chk("done", bus.done, (k == done_k));
                if (k == done_k) begin
                    chk("nvalid", nv, len);
                    chk("err_cnt", bus.err_cnt, err_exp);
                    chk("pass", bus.pass, (err_exp == 0));
                    last_pass = (err_exp == 0);
                    fin = 1'b1;
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        run(20, 1, 0, 0, 0);
        run(40, 21, 0, 0, 0);
        mem[45] = 8'hFF;
        mem[50] = 8'h00;
        run(40, 21, 0, 0, 0);
        mem[45] = 8'd45;
        mem[50] = 8'd50;
        run(250, 10, 0, 0, 0);
        run(7, 0, 0, 0, 0);
        run(40, 21, 3, 25, 0);
        run(40, 21, 0, 0, 0);
        run(40, 21, 0, 0, 10);
        chk_zero("post_rst");
        run(100, 5, 0, 0, 0);
        run(0, N, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            int b, l, ia;
            if ($urandom_range(0, 2) == 0)
                mem[$urandom_range(0, N - 1)] = DW'($urandom);
            b = $urandom_range(0, N - 1);
            l = $urandom_range(0, 40);
            ia = $urandom_range(0, 3) == 0 ? $urandom_range(1, l + LAT + 2) : 0;
            run(b, l, ia, 0, 0);
        end

        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
